// File: rtl/sa_stream_pkg.sv
// Shared defaults and helpers for the systolic-array result stream path.
// Holds the element geometry used by the AXI wrapper and the serializer FSM states.
package sa_stream_pkg;

    localparam int unsigned SA_ELEM_W   = 16;
    localparam int unsigned SA_NUM_ELEM = 9;
    localparam int unsigned SA_OUT_W    = 32;

    typedef enum logic {StIdle, StSend} sa_ser_state_e;

    function automatic int unsigned num_beats(input int unsigned elem_w,
                                              input int unsigned num_elem,
                                              input int unsigned out_w);
        int unsigned epb;
        epb = out_w / elem_w;
        return (num_elem + epb - 1) / epb;
    endfunction

    // Byte enables of the final beat: only bytes that carry real elements.
    function automatic logic [63:0] last_keep(input int unsigned elem_w,
                                              input int unsigned num_elem,
                                              input int unsigned out_w);
        int unsigned epb;
        int unsigned rem;
        int unsigned nbytes;
        epb    = out_w / elem_w;
        rem    = num_elem - (num_beats(elem_w, num_elem, out_w) - 1) * epb;
        nbytes = rem * elem_w / 8;
        return (64'd1 << nbytes) - 64'd1;
    endfunction

endpackage

// File: rtl/sa_result_serializer_if.sv
// Handshake bundle between the systolic-array wrapper, the serializer and the DMA.
// slave is the serializer's view; master is the view of whoever drives it.
interface sa_result_serializer_if #(
    parameter int unsigned ELEM_W   = sa_stream_pkg::SA_ELEM_W,
    parameter int unsigned NUM_ELEM = sa_stream_pkg::SA_NUM_ELEM,
    parameter int unsigned OUT_W    = sa_stream_pkg::SA_OUT_W
) ();

    logic                         s_axis_valid;
    logic [ELEM_W*NUM_ELEM-1:0]   s_axis_data;
    logic                         s_axis_ready;
    logic                         m_axis_valid;
    logic [OUT_W-1:0]             m_axis_data;
    logic [OUT_W/8-1:0]           m_axis_keep;
    logic                         m_axis_last;
    logic                         m_axis_ready;

    modport slave (
        input  s_axis_valid, s_axis_data, m_axis_ready,
        output s_axis_ready, m_axis_valid, m_axis_data, m_axis_keep, m_axis_last
    );

    modport master (
        output s_axis_valid, s_axis_data, m_axis_ready,
        input  s_axis_ready, m_axis_valid, m_axis_data, m_axis_keep, m_axis_last
    );

endinterface

// File: rtl/sa_result_pend_buf.sv
// One-entry pending buffer with full flag; only built when SA_SER_DOUBLE_BUF_EN is defined.
// A push in the same cycle as a pop replaces the drained entry.
`ifdef SA_SER_DOUBLE_BUF_EN
module sa_result_pend_buf #(
    parameter int unsigned Width = 144
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] data_o,
    output logic             full_o
);

    logic             full_q, full_d;
    logic [Width-1:0] data_q, data_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (pop_i) begin
            full_d = 1'b0;
        end
        if (push_i) begin
            full_d = 1'b1;
            data_d = data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign data_o = data_q;
    assign full_o = full_q;

endmodule
`endif

// File: rtl/sa_result_serializer.sv
// Splits one packed 3x3 result matrix into OUT_W-wide AXI-Stream beats with TKEEP/TLAST.
// Define SA_SER_DOUBLE_BUF_EN to add a pending matrix buffer for bubble-free streaming.
module sa_result_serializer #(
    parameter int unsigned ELEM_W   = sa_stream_pkg::SA_ELEM_W,
    parameter int unsigned NUM_ELEM = sa_stream_pkg::SA_NUM_ELEM,
    parameter int unsigned OUT_W    = sa_stream_pkg::SA_OUT_W
) (
    input  logic                   axi_clk,
    input  logic                   axi_rst,
    sa_result_serializer_if.slave  bus
);

    import sa_stream_pkg::*;

    localparam int unsigned InW      = ELEM_W * NUM_ELEM;
    localparam int unsigned KeepW    = OUT_W / 8;
    localparam int unsigned NumBeats = num_beats(ELEM_W, NUM_ELEM, OUT_W);
    localparam int unsigned HoldW    = NumBeats * OUT_W;
    localparam int unsigned IdxW     = (NumBeats > 1) ? $clog2(NumBeats) : 1;
    localparam logic [KeepW-1:0] LastKeep = KeepW'(last_keep(ELEM_W, NUM_ELEM, OUT_W));
    localparam logic [IdxW-1:0]  LastIdx  = IdxW'(NumBeats - 1);

    sa_ser_state_e   state_q, state_d;
    logic [IdxW-1:0] beat_idx_q, beat_idx_d;
    // Padded to whole beats so slots past NUM_ELEM read back as zero.
    logic [HoldW-1:0] hold_q, hold_d;
    logic             beat_last;
    logic             sending;

    assign sending   = (state_q == StSend);
    assign beat_last = (beat_idx_q == LastIdx);

`ifdef SA_SER_DOUBLE_BUF_EN
    logic           pend_push;
    logic           pend_pop;
    logic           pend_full;
    logic [InW-1:0] pend_data;

    sa_result_pend_buf #(
        .Width (InW)
    ) u_pend_buf (
        .clk_i  (axi_clk),
        .rst_i  (axi_rst),
        .push_i (pend_push),
        .pop_i  (pend_pop),
        .data_i (bus.s_axis_data),
        .data_o (pend_data),
        .full_o (pend_full)
    );

    assign bus.s_axis_ready = !sending || !pend_full;
`else
    assign bus.s_axis_ready = !sending;
`endif

    always_comb begin
        state_d    = state_q;
        beat_idx_d = beat_idx_q;
        hold_d     = hold_q;
`ifdef SA_SER_DOUBLE_BUF_EN
        pend_push  = 1'b0;
        pend_pop   = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.s_axis_valid) begin
                    hold_d     = HoldW'(bus.s_axis_data);
                    beat_idx_d = '0;
                    state_d    = StSend;
                end
            end
            StSend: begin
                if (bus.m_axis_ready && beat_last) begin
                    beat_idx_d = '0;
`ifdef SA_SER_DOUBLE_BUF_EN
                    // Next matrix comes from pending first, else straight from the input.
                    if (pend_full) begin
                        hold_d   = HoldW'(pend_data);
                        pend_pop = 1'b1;
                    end else if (bus.s_axis_valid) begin
                        hold_d = HoldW'(bus.s_axis_data);
                    end else begin
                        state_d = StIdle;
                    end
`else
                    state_d = StIdle;
`endif
                end else begin
                    if (bus.m_axis_ready) begin
                        beat_idx_d = beat_idx_q + 1'b1;
                    end
`ifdef SA_SER_DOUBLE_BUF_EN
                    pend_push = bus.s_axis_valid && !pend_full;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            state_q    <= StIdle;
            beat_idx_q <= '0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            beat_idx_q <= beat_idx_d;
            hold_q     <= hold_d;
        end
    end

    always_comb begin
        bus.m_axis_valid = sending;
        bus.m_axis_data  = '0;
        bus.m_axis_keep  = '0;
        bus.m_axis_last  = 1'b0;
        if (sending) begin
            bus.m_axis_data = hold_q[beat_idx_q*OUT_W +: OUT_W];
            bus.m_axis_keep = beat_last ? LastKeep : {KeepW{1'b1}};
            bus.m_axis_last = beat_last;
        end
    end

endmodule
